// File: rtl/snake_cell_plotter_pkg.sv
// Shared graphics definitions for the snake pixel engine: FSM states,
// screen geometry derived from the resolution choice, and game colours.
package snake_cell_plotter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_CLEAR,
        S_FIN
    } state_t;

    localparam int SCREEN_W_LO = 160;
    localparam int SCREEN_H_LO = 120;
    localparam int SCREEN_W_HI = 320;
    localparam int SCREEN_H_HI = 240;

    localparam logic [2:0] COLOUR_BG    = 3'b000;
    localparam logic [2:0] COLOUR_SNAKE = 3'b010;
    localparam logic [2:0] COLOUR_FOOD  = 3'b100;

    function automatic int screen_w(bit hires);
        return hires ? SCREEN_W_HI : SCREEN_W_LO;
    endfunction

    function automatic int screen_h(bit hires);
        return hires ? SCREEN_H_HI : SCREEN_H_LO;
    endfunction

    function automatic int x_width(bit hires);
        return hires ? 9 : 8;
    endfunction

    function automatic int y_width(bit hires);
        return hires ? 8 : 7;
    endfunction

endpackage

// File: rtl/snake_cell_plotter_if.sv
// Command/pixel bundle between the game FSM (master) and the plotter
// (slave); the pixel side feeds the frame buffer write port.
interface snake_cell_plotter_if #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3
);
    logic          clear_req;
    logic          draw_req;
    logic [5:0]    cell_x;
    logic [4:0]    cell_y;
    logic [CW-1:0] cell_colour;
    logic          ready;
    logic          done;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;

    modport master (
        output clear_req, draw_req, cell_x, cell_y, cell_colour,
        input  ready, done, x, y, colour, plot
    );

    modport slave (
        input  clear_req, draw_req, cell_x, cell_y, cell_colour,
        output ready, done, x, y, colour, plot
    );
endinterface

// File: rtl/snake_cell_plotter_scan_counter.sv
// vga_scan_counter: 2-D x/y counter with clear, enable, run-time wrap
// limits and a flag marking the final (x_max, y_max) position.
module vga_scan_counter #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [XW-1:0] x_max,
    input  logic [YW-1:0] y_max,
    output logic [XW-1:0] x_next,
    output logic [YW-1:0] y_next,
    output logic          last
);
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          wrap_x;
    logic          wrap_y;

    assign wrap_x = (x_q == x_max);
    assign wrap_y = (y_q == y_max);
    assign last   = wrap_x && wrap_y;

    // Next position is exported so the owner can register pixel outputs
    // in the same cycle the counter advances.
    always_comb begin
        x_next = x_q;
        y_next = y_q;
        if (clr) begin
            x_next = '0;
            y_next = '0;
        end else if (en) begin
            if (wrap_x) begin
                x_next = '0;
                y_next = wrap_y ? '0 : y_q + YW'(1);
            end else begin
                x_next = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_next;
            y_q <= y_next;
        end
    end
endmodule

// File: rtl/snake_cell_plotter.sv
// Snake pixel-write engine: cell fill and full-screen clear, one pixel per
// clock. Define CELL_OUTLINE_EN to paint each cell's outer ring in CLEAR_COLOUR.
module snake_cell_plotter
    import snake_cell_plotter_pkg::*;
#(
    parameter string RESOLUTION = "160x120",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter int    CELL_SIZE = 4,
    parameter logic [3*BITS_PER_COLOUR_CHANNEL-1:0] CLEAR_COLOUR = '0
) (
    input logic clock,
    input logic reset,
    snake_cell_plotter_if.slave bus
);
    localparam bit HIRES = (RESOLUTION == "320x240");
    localparam int SW    = screen_w(HIRES);
    localparam int SH    = screen_h(HIRES);
    localparam int XW    = x_width(HIRES);
    localparam int YW    = y_width(HIRES);
    localparam int CW    = 3 * BITS_PER_COLOUR_CHANNEL;
    localparam int SHIFT = $clog2(CELL_SIZE);
    localparam int GW    = SW / CELL_SIZE;
    localparam int GH    = SH / CELL_SIZE;

    state_t        state, state_n;
    logic          oor_q, oor_n;
    logic [5:0]    cx_q;
    logic [4:0]    cy_q;
    logic [CW-1:0] cc_q;
    logic          ready_q, done_q, plot_q;
    logic          done_n, plot_n;
    logic [XW-1:0] x_q, x_n;
    logic [YW-1:0] y_q, y_n;
    logic [CW-1:0] colour_q, colour_n;

    logic          cnt_clr, cnt_en, last;
    logic [XW-1:0] nox, xmax;
    logic [YW-1:0] noy, ymax;

    logic          accept_draw;
    logic          out_of_range;
    logic [5:0]    bx;
    logic [4:0]    by;
    logic [CW-1:0] bc;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] pix_c;

    vga_scan_counter #(
        .XW(XW),
        .YW(YW)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .x_max  (xmax),
        .y_max  (ymax),
        .x_next (nox),
        .y_next (noy),
        .last   (last)
    );

    assign accept_draw  = (state == S_IDLE) && !bus.clear_req
                          && bus.draw_req;
    assign out_of_range = (int'(bus.cell_x) >= GW)
                          || (int'(bus.cell_y) >= GH);

    // The first pixel is registered on the accepting edge, before the
    // captured copies of the command are available.
    assign bx = accept_draw ? bus.cell_x : cx_q;
    assign by = accept_draw ? bus.cell_y : cy_q;
    assign bc = accept_draw ? bus.cell_colour : cc_q;

    assign pix_x = XW'((int'(bx) << SHIFT) + int'(nox));
    assign pix_y = YW'((int'(by) << SHIFT) + int'(noy));

`ifdef CELL_OUTLINE_EN
    logic ring;
    assign ring  = (nox == '0) || (nox == XW'(CELL_SIZE - 1))
                   || (noy == '0) || (noy == YW'(CELL_SIZE - 1));
    assign pix_c = ring ? CLEAR_COLOUR : bc;
`else
    assign pix_c = bc;
`endif

    assign xmax = (state == S_CLEAR) ? XW'(SW - 1) : XW'(CELL_SIZE - 1);
    assign ymax = (state == S_CLEAR) ? YW'(SH - 1) : YW'(CELL_SIZE - 1);

    always_comb begin
        state_n  = state;
        oor_n    = oor_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        done_n   = 1'b0;
        plot_n   = 1'b0;
        x_n      = x_q;
        y_n      = y_q;
        colour_n = colour_q;
        unique case (state)
            S_IDLE: begin
                if (bus.clear_req) begin
                    state_n  = S_CLEAR;
                    cnt_clr  = 1'b1;
                    plot_n   = 1'b1;
                    x_n      = '0;
                    y_n      = '0;
                    colour_n = CLEAR_COLOUR;
                end else if (bus.draw_req && out_of_range) begin
                    state_n = S_FIN;
                    oor_n   = 1'b1;
                end else if (bus.draw_req) begin
                    state_n  = S_DRAW;
                    cnt_clr  = 1'b1;
                    plot_n   = 1'b1;
                    x_n      = pix_x;
                    y_n      = pix_y;
                    colour_n = pix_c;
                end
            end
            S_DRAW: begin
                if (last) begin
                    state_n = S_FIN;
                    done_n  = 1'b1;
                end else begin
                    cnt_en   = 1'b1;
                    plot_n   = 1'b1;
                    x_n      = pix_x;
                    y_n      = pix_y;
                    colour_n = pix_c;
                end
            end
            S_CLEAR: begin
                if (last) begin
                    state_n = S_FIN;
                    done_n  = 1'b1;
                end else begin
                    cnt_en   = 1'b1;
                    plot_n   = 1'b1;
                    x_n      = nox;
                    y_n      = noy;
                    colour_n = CLEAR_COLOUR;
                end
            end
            S_FIN: begin
                // A rejected cell spends one silent cycle here first.
                if (oor_q) begin
                    oor_n  = 1'b0;
                    done_n = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            oor_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            cc_q     <= '0;
        end else begin
            state    <= state_n;
            oor_q    <= oor_n;
            ready_q  <= (state_n == S_IDLE);
            done_q   <= done_n;
            plot_q   <= plot_n;
            x_q      <= x_n;
            y_q      <= y_n;
            colour_q <= colour_n;
            if (accept_draw) begin
                cx_q <= bus.cell_x;
                cy_q <= bus.cell_y;
                cc_q <= bus.cell_colour;
            end
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.plot   = plot_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
endmodule

// File: tb/tb_snake_cell_plotter.sv
// Directed bench for snake_cell_plotter at 160x120, CELL_SIZE 4,
// CLEAR_COLOUR 3'b001.
module tb_snake_cell_plotter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    localparam logic [2:0] CLR_C = 3'b001;

    snake_cell_plotter_if #(.XW(8), .YW(7), .CW(3)) bus ();

    snake_cell_plotter #(
        .RESOLUTION              ("160x120"),
        .BITS_PER_COLOUR_CHANNEL (1),
        .CELL_SIZE               (4),
        .CLEAR_COLOUR            (CLR_C)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cx;
        int         cy;
        logic [2:0] col;
        int         ex;
        int         ey;
        bit         oor;
    } vec_t;

    vec_t vecs[6];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pix(logic p, int px, int py,
                                        logic [2:0] c);
        logic [7:0] xx;
        logic [6:0] yy;
        xx = px[7:0];
        yy = py[6:0];
        return {13'd0, p, xx, yy, c};
    endfunction

    function automatic logic [31:0] dut_pix();
        return {13'd0, bus.plot, bus.x, bus.y, bus.colour};
    endfunction

    task automatic run_draw(vec_t v, string tag);
        logic [2:0] ec;
        check({tag, "_pre_ready"}, 32'(bus.ready), 32'd1);
        bus.draw_req    = 1'b1;
        bus.cell_x      = v.cx[5:0];
        bus.cell_y      = v.cy[4:0];
        bus.cell_colour = v.col;
        tick();
        bus.draw_req    = 1'b0;
        bus.cell_x      = 6'd0;
        bus.cell_y      = 5'd0;
        bus.cell_colour = 3'd0;
        if (v.oor) begin
            check({tag, "_oor_c1"},
                  {29'd0, bus.plot, bus.done, bus.ready}, 32'd0);
            tick();
            check({tag, "_oor_c2"},
                  {29'd0, bus.plot, bus.done, bus.ready}, 32'b010);
            tick();
            check({tag, "_oor_c3"},
                  {29'd0, bus.plot, bus.done, bus.ready}, 32'b001);
        end else begin
            for (int k = 0; k < 16; k++) begin
                int ox = k % 4;
                int oy = k / 4;
                ec = v.col;
`ifdef CELL_OUTLINE_EN
                if (ox == 0 || ox == 3 || oy == 0 || oy == 3) ec = CLR_C;
`endif
                check({tag, "_pix"}, dut_pix(),
                      pix(1'b1, v.ex + ox, v.ey + oy, ec));
                if (k == 0)
                    check({tag, "_busy"},
                          {30'd0, bus.ready, bus.done}, 32'd0);
                tick();
            end
            check({tag, "_done"}, {30'd0, bus.plot, bus.done}, 32'b01);
            tick();
            check({tag, "_idle"}, {30'd0, bus.ready, bus.done}, 32'b10);
        end
    endtask

    initial begin
        int bad, first_bad, plots, dones;
        logic [31:0] first_act, first_exp;

        vecs[0] = '{cx: 2,  cy: 3,  col: 3'b100, ex: 8,   ey: 12,  oor: 0};
        vecs[1] = '{cx: 0,  cy: 0,  col: 3'b010, ex: 0,   ey: 0,   oor: 0};
        vecs[2] = '{cx: 39, cy: 29, col: 3'b111, ex: 156, ey: 116, oor: 0};
        vecs[3] = '{cx: 40, cy: 0,  col: 3'b110, ex: 0,   ey: 0,   oor: 1};
        vecs[4] = '{cx: 0,  cy: 30, col: 3'b110, ex: 0,   ey: 0,   oor: 1};
        vecs[5] = '{cx: 10, cy: 5,  col: 3'b011, ex: 40,  ey: 20,  oor: 0};

        bus.clear_req   = 1'b0;
        bus.draw_req    = 1'b0;
        bus.cell_x      = 6'd0;
        bus.cell_y      = 5'd0;
        bus.cell_colour = 3'd0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("reset_ctl", {29'd0, bus.ready, bus.done, bus.plot}, 32'b100);
        check("reset_pix", dut_pix(), pix(1'b0, 0, 0, 3'd0));

        for (int i = 0; i < 6; i++) run_draw(vecs[i], $sformatf("vec%0d", i));

        // Full clear with raster-order check.
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        bad = 0;
        first_bad = -1;
        first_act = '0;
        first_exp = '0;
        for (int i = 0; i < 19200; i++) begin
            if (dut_pix() !== pix(1'b1, i % 160, i / 160, CLR_C)) begin
                if (first_bad < 0) begin
                    first_bad = i;
                    first_act = dut_pix();
                    first_exp = pix(1'b1, i % 160, i / 160, CLR_C);
                end
                bad++;
            end
            if (i == 19199)
                check("clear_last_pix", dut_pix(), pix(1'b1, 159, 119, CLR_C));
            if (i == 9000)
                check("clear_busy", {30'd0, bus.ready, bus.done}, 32'd0);
            tick();
        end
        if (first_bad >= 0)
            $display("FAIL clear_first_bad idx %0d: got %h expected %h",
                     first_bad, first_act, first_exp);
        check("clear_raster_bad", 32'(bad), 32'd0);
        check("clear_done", {30'd0, bus.plot, bus.done}, 32'b01);
        tick();
        check("clear_idle", {30'd0, bus.ready, bus.done}, 32'b10);

        // Simultaneous requests: clear wins; busy requests ignored.
        bus.clear_req   = 1'b1;
        bus.draw_req    = 1'b1;
        bus.cell_x      = 6'd1;
        bus.cell_y      = 5'd1;
        bus.cell_colour = 3'b111;
        tick();
        bus.clear_req = 1'b0;
        bus.draw_req  = 1'b0;
        check("both_first_pix", dut_pix(), pix(1'b1, 0, 0, CLR_C));
        plots = 0;
        dones = 0;
        for (int i = 0; i < 19300; i++) begin
            if (bus.plot === 1'b1) plots++;
            if (bus.done === 1'b1) dones++;
            bus.draw_req  = (i < 19000) && (i % 997 == 5);
            bus.clear_req = (i < 19000) && (i % 1511 == 7);
            tick();
        end
        bus.draw_req  = 1'b0;
        bus.clear_req = 1'b0;
        check("both_plot_count", 32'(plots), 32'd19200);
        check("both_done_count", 32'(dones), 32'd1);
        check("both_idle", {31'd0, bus.ready}, 32'd1);

        // Reset in the middle of a clear.
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (500) tick();
        check("mid_pix500", dut_pix(), pix(1'b1, 20, 3, CLR_C));
        reset = 1'b1;
        tick();
        check("mid_rst_ctl", {29'd0, bus.ready, bus.done, bus.plot}, 32'b100);
        check("mid_rst_pix", dut_pix(), pix(1'b0, 0, 0, 3'd0));
        reset = 1'b0;
        tick();
        check("mid_after_ctl", {29'd0, bus.ready, bus.done, bus.plot},
              32'b100);
        run_draw('{cx: 5, cy: 5, col: 3'b010, ex: 20, ey: 20, oor: 0},
                 "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
